// File: rtl/loader_pkg.sv
// +----------------------------------------------------------------------------+
// | loader_pkg                                                                 |
// | Shared state encoding, error codes and framing defaults for uart_loader.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/uart_byte_strobe.sv
// +----------------------------------------------------------------------------+
// | uart_byte_strobe                                                           |
// | Turns the level-style rx_done into a single registered byte strobe.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_byte_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       byte_vld,
  output logic [7:0] byte_q
);

  logic       rx_done_q, rx_done_d;
  logic       vld_q, vld_d;
  logic [7:0] data_q, data_d;
  logic       rise;

  always_comb begin
    rise      = rx_done & ~rx_done_q;
    rx_done_d = rx_done;
    vld_d     = rise;
    data_d    = rise ? rx_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      rx_done_q <= rx_done_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
    end
  end

  assign byte_vld = vld_q;
  assign byte_q   = data_q;

endmodule

`default_nettype wire

// File: rtl/uart_loader.sv
// +----------------------------------------------------------------------------+
// | uart_loader                                                                |
// | Parses a framed program image from UART bytes and writes it to imem.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W         = 14,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 4_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              load_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic       byte_vld;
  logic [7:0] byte_q;

  uart_byte_strobe u_strobe (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .byte_vld (byte_vld),
    .byte_q   (byte_q)
  );

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       shift_q, shift_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [15:0]       len_n;
  logic              in_frame;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    shift_d     = shift_q;
    bidx_d      = bidx_q;
    word_cnt_d  = word_cnt_q;
    xor_d       = xor_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    code_d      = code_q;
    len_n       = {byte_q, len_q[7:0]};
    in_frame    = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                  (state_q == ST_DATA) || (state_q == ST_CHK);

    // Dropping load_en wins over any byte or timeout and never flags an error.
    if ((state_q != ST_IDLE) && !load_en) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_vld && load_en && (byte_q == SYNC_BYTE)) begin
            state_d    = ST_LEN0;
            xor_d      = 8'h00;
            word_cnt_d = '0;
            bidx_d     = 2'd0;
            tmo_d      = '0;
          end
        end
        ST_LEN0: begin
          if (byte_vld) begin
            len_d[7:0] = byte_q;
            state_d    = ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (byte_vld) begin
            len_d = len_n;
            if (32'(len_n) > (32'd1 << ADDR_W)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              code_d  = ERR_LEN;
            end else if (len_n == 16'd0) begin
              state_d = ST_CHK;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_vld) begin
            xor_d  = xor_q ^ byte_q;
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_cnt_q[ADDR_W-1:0];
              mem_wdata_d = {byte_q, shift_q};
              word_cnt_d  = word_cnt_q + (ADDR_W+1)'(1);
              if ((32'(word_cnt_q) + 32'd1) == 32'(len_q))
                state_d = ST_CHK;
            end else begin
              shift_d = {byte_q, shift_q[23:8]};
            end
          end
        end
        ST_CHK: begin
          if (byte_vld) begin
            if (byte_q == xor_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              code_d  = ERR_CHK;
            end
          end
        end
        default: ;
      endcase

      // An arriving byte always restarts the idle window, even on the last tick.
      if (in_frame) begin
        if (byte_vld) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    end

    cpu_hold_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    busy_d     = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_CHK);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      shift_q     <= '0;
      bidx_q      <= '0;
      word_cnt_q  <= '0;
      xor_q       <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      bidx_q      <= bidx_d;
      word_cnt_q  <= word_cnt_d;
      xor_q       <= xor_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign err_code  = code_q;
  assign word_cnt  = word_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_loader.sv
// +----------------------------------------------------------------------------+
// | tb_uart_loader                                                             |
// | Directed and randomized frame checks for uart_loader.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_loader;

  localparam int ADDR_W = 14;
  localparam int TMO    = 1000;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              load_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_cnt;

  uart_loader #(
    .ADDR_W         (ADDR_W),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .load_en   (load_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code),
    .word_cnt  (word_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [7:0]        seq[$];
  logic [31:0]       exp_words[$];

  always @(negedge sys_clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int hold;
    int gap;
    hold = $urandom_range(1, 3);
    gap  = $urandom_range(0, 2);
    tick();
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
    repeat (4) tick();
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Reference: a frame of n random words; checksum is the XOR of all payload bytes.
  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] n16;
    x   = 8'h00;
    n16 = 16'(n);
    seq.delete();
    exp_words.delete();
    seq.push_back(8'hA5);
    seq.push_back(n16[7:0]);
    seq.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_words.push_back(w);
      for (int k = 0; k < 4; k++) begin
        seq.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    seq.push_back(x);
  endtask

  task automatic check_frame(input string tag, input bit good);
    check({tag, "_nwr"}, 96'(wa_q.size()), 96'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++) begin
      if (i < wa_q.size()) begin
        check({tag, "_addr"}, 96'(wa_q[i]), 96'(i));
        check({tag, "_data"}, 96'(wd_q[i]), 96'(exp_words[i]));
      end
    end
    check({tag, "_done"}, 96'(load_done), 96'(good));
    check({tag, "_err"}, 96'(load_err), 96'(!good));
    check({tag, "_code"}, 96'(err_code), good ? 96'd0 : 96'd2);
    check({tag, "_hold"}, 96'(cpu_hold), 96'(!good));
    check({tag, "_busy"}, 96'(load_busy), 96'd0);
    check({tag, "_wcnt"}, 96'(word_cnt), 96'(exp_words.size()));
  endtask

  task automatic leave_frame(input string tag);
    tick();
    load_en = 1'b0;
    tick();
    tick();
    check({tag, "_flags_off"}, 96'({cpu_hold, load_busy, load_done, load_err, err_code}), 96'd0);
    load_en = 1'b1;
    tick();
    clear_writes();
  endtask

  function automatic logic [95:0] all_outs();
    return 96'({mem_we, mem_addr, mem_wdata, cpu_hold, load_busy,
                load_done, load_err, err_code, word_cnt});
  endfunction

  initial begin
    int waited;
    int n;
    bit bad;
    logic [7:0] j;

    sys_rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    load_en = 1'b0;
    repeat (3) tick();
    check("reset_outs", all_outs(), 96'd0);
    sys_rst = 1'b0;
    tick();

    // Bytes while load_en is low are ignored.
    send_byte(8'hA5);
    repeat (3) tick();
    load_en = 1'b1;
    tick();
    check("en_low_ignored", 96'(load_busy), 96'd0);

    // Two-word directed load.
    seq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    exp_words = '{32'h12345678, 32'hDEADBEEF};
    send_byte(seq[0]);
    repeat (3) tick();
    check("sync_busy", 96'({cpu_hold, load_busy}), 96'b11);
    seq.delete(0);
    send_seq();
    check_frame("two_word", 1'b1);

    // DONE is sticky while load_en stays high.
    send_byte(8'hA5);
    repeat (4) tick();
    check("done_sticky", 96'({load_done, load_busy}), 96'b10);
    leave_frame("two_word");

    // Same frame with a wrong checksum.
    seq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    send_seq();
    check_frame("chk_err", 1'b0);
    leave_frame("chk_err");

    // Length one beyond capacity.
    seq = '{8'hA5, 8'h01, 8'h40};
    send_seq();
    check("len_err", 96'({load_err, err_code, cpu_hold, load_busy}), 96'b10110);
    check("len_nwr", 96'(wa_q.size()), 96'd0);
    leave_frame("len_err");

    // Exactly full capacity is accepted as a data frame.
    seq = '{8'hA5, 8'h00, 8'h40};
    send_seq();
    check("len_max_ok", 96'({load_err, load_busy}), 96'b01);
    leave_frame("len_max");

    // Zero-length frame.
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    exp_words.delete();
    send_seq();
    check_frame("zero_len", 1'b1);
    leave_frame("zero_len");

    // Randomized frames with leading junk bytes against the model.
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(1, 6);
      bad = 1'($urandom_range(0, 1));
      j   = 8'($urandom);
      if (j == 8'hA5) j = 8'h5A;
      send_byte(j);
      build_frame(n, bad);
      send_seq();
      check_frame("rand", !bad);
      leave_frame("rand");
    end

    // rx_done held high on the sync byte must consume it once only.
    tick();
    rx_data = 8'hA5;
    rx_done = 1'b1;
    repeat (500) tick();
    check("level_busy", 96'({load_busy, load_done}), 96'b10);
    rx_done = 1'b0;
    tick();
    seq = '{8'h00, 8'h00, 8'h00};
    exp_words.delete();
    send_seq();
    check_frame("level", 1'b1);
    leave_frame("level");

    // Abort arriving in the same cycle as the 4th data byte strobe.
    seq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (seq[i]) send_byte(seq[i]);
    tick();
    rx_data = 8'h44;
    rx_done = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    check("abort_idle", 96'({cpu_hold, load_busy, load_err, err_code}), 96'd0);
    rx_done = 1'b0;
    repeat (3) tick();
    check("abort_nwr", 96'(wa_q.size()), 96'd0);
    load_en = 1'b1;
    seq = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_seq();
    check("abort_after", 96'({wa_q.size() != 0, load_busy}), 96'd0);
    clear_writes();

    // Timeout mid-word: no write may appear.
    seq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
    foreach (seq[i]) send_byte(seq[i]);
    repeat (TMO - 60) tick();
    check("tmo_not_yet", 96'({load_busy, load_err}), 96'b10);
    waited = 0;
    while (load_err !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    check("tmo_err", 96'({load_err, err_code, cpu_hold, load_busy}), 96'b11110);
    check("tmo_nwr", 96'(wa_q.size()), 96'd0);
    leave_frame("tmo");

    // Asynchronous reset in the middle of a frame.
    seq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (seq[i]) send_byte(seq[i]);
    repeat (3) tick();
    check("pre_rst_wr", 96'({wa_q.size(), wd_q.size() > 0 ? wd_q[0] : 32'h0}),
          96'({32'd1, 32'h44332211}));
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    check("async_rst", all_outs(), 96'd0);
    tick();
    sys_rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Byte-stream boot loader controller that sits directly behind the UART receiver.
- Parses a framed program image from received bytes, assembles 32-bit little-endian words and writes them sequentially into instruction memory.
- Holds the CPU in reset while a load is in progress, and reports done or error status to the board-level LEDs and the CPU reset logic.

Parameters:
- ADDR_W, 14: word-address width of instruction memory; capacity is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 4_000_000: maximum idle sys_clk cycles between bytes inside a frame (100 ms at 40 MHz).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- rx_done  in  1  byte-available flag from the UART receiver. It is a level that may stay high for many cycles.
- rx_data  in  8  received byte, valid while rx_done is high.
- load_en  in  1  load mode enable (board switch, already synchronised).
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- cpu_hold  out  1  holds the CPU in reset.
- load_busy  out  1  a frame is in progress.
- load_done  out  1  frame accepted with a correct checksum.
- load_err  out  1  frame rejected.
- err_code  out  2  error cause: 00 none, 01 length, 10 checksum, 11 timeout.
- word_cnt  out  ADDR_W+1  number of words written in the current or last frame.

Behaviour:
- Byte strobe: a byte is accepted only on a rx_done 0->1 transition. The internal strobe is registered, so there is one cycle of latency after the rx_done rise. rx_data is sampled in the same cycle as the edge. rx_done held high never produces a second byte.
- Frame format, in order:
  - SYNC_BYTE.
  - LEN_LO, LEN_HI: 16-bit word count N.
  - 4*N payload bytes, least significant byte of each word first.
  - CHK: XOR of all payload bytes.
- States and transitions:
  - IDLE: wait for load_en=1 and a SYNC_BYTE byte -> LEN0. Non-sync bytes are ignored. Bytes arriving while load_en=0 are ignored.
  - LEN0: latch the low byte -> LEN1.
  - LEN1: latch the high byte.
    - N > 2^ADDR_W -> ERR with code 01.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA: shift bytes into the word register. On the 4th byte:
    - Next cycle: mem_we=1 for exactly one cycle, mem_addr = current word index, mem_wdata = assembled word.
    - The word index and word_cnt increment.
    - After word N -> CHK.
  - CHK: byte == running XOR -> DONE; otherwise -> ERR with code 10.
  - DONE and ERR: sticky until load_en=0, then -> IDLE. Status flags are cleared on leaving. A new SYNC_BYTE is not honoured until that IDLE pass.
- Timeout: the counter clears on every accepted byte and runs in LEN0, LEN1, DATA and CHK. Reaching TIMEOUT_CYCLES -> ERR with code 11. No partial word is written.
- Outputs per state:
  - cpu_hold = 1 in LEN0, LEN1, DATA, CHK and ERR; 0 in IDLE and DONE.
  - load_busy = 1 in LEN0 through CHK.
- Abort: load_en falling in any non-IDLE state -> IDLE on the next cycle. A pending write does not issue, cpu_hold drops, and no error is flagged.
- Simultaneous events:
  - Abort beats a byte strobe in the same cycle.
  - A byte strobe beats a timeout in the same cycle; the counter clears.
- The word index wraps only via the length check, so it never exceeds 2^ADDR_W-1.
- The running XOR and word index clear on entry to LEN0.
- Reset: every output is 0, state is IDLE, all counters are 0. Reset mid-frame discards the frame immediately.
- All outputs are registered.

Decomposition:
- Shared package loader_pkg holds:
  - state enum (IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR);
  - err_code constants ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO;
  - SYNC_BYTE default.
- One sub-module: uart_byte_strobe, containing the rx_done edge detector and rx_data capture register, producing a one-cycle byte_vld and byte_q.

Test Plan:
- Load two words: bytes A5 02 00 78 56 34 12 EF BE AD DE 2A.
  - mem_we pulses twice: addr 0 with 0x12345678, addr 1 with 0xDEADBEEF.
  - Then load_done=1, cpu_hold=0, word_cnt=2, err_code=00.
- Checksum error: same frame with CHK=2B.
  - Both writes occur, then load_err=1, err_code=10, cpu_hold stays 1.
  - Dropping load_en returns to IDLE with all flags 0.
- Length error, ADDR_W=14: A5 01 40 (N=16385).
  - ERR with code 01 immediately after LEN_HI; zero writes.
- Timeout: A5 01 00 78 56, then silence for TIMEOUT_CYCLES.
  - ERR with code 11; no mem_we at any point.
- Level and abort:
  - rx_done held high for 500 cycles on byte A5 -> only one byte is consumed.
  - load_en drops mid-DATA -> IDLE next cycle with no further mem_we.
  - Assert sys_rst mid-frame -> all outputs 0 asynchronously.
- Zero-length frame: A5 00 00 00 -> load_done=1, word_cnt=0, no writes.
